// File: rtl/snitch_pkg.sv
// Sv32 address, PTE and TLB types shared by the VM translation blocks.
// Pure type/constant package; no logic.
package snitch_pkg;
  localparam int unsigned PageShift = 12;
  localparam int unsigned VpnSize   = 10;
  localparam int unsigned Ppn1Size  = 12;

  typedef struct packed {
    logic [VpnSize-1:0]   vpn1;
    logic [VpnSize-1:0]   vpn0;
    logic [PageShift-1:0] offset;
  } va_t;

  typedef struct packed {
    logic [Ppn1Size-1:0] ppn1;
    logic [VpnSize-1:0]  ppn0;
  } pa_t;

  typedef struct packed {
    logic d;
    logic a;
    logic u;
    logic x;
    logic w;
    logic r;
  } pte_flags_t;

  typedef struct packed {
    pa_t        pa;
    pte_flags_t flags;
  } l0_pte_t;

  typedef struct packed {
    logic               valid;
    logic [VpnSize-1:0] vpn1;
    logic [VpnSize-1:0] vpn0;
    logic               is_4mega;
    l0_pte_t            pte;
  } tlb_entry_t;

  typedef enum logic [1:0] {Idle, Refill, Respond} tlb_state_e;
endpackage

// File: rtl/snitch_vm_tlb_victim.sv
// Victim pick: lowest free slot, else round-robin pointer. Combinational index,
// pointer advances only when an install lands in a full array.
module snitch_vm_tlb_victim #(
  parameter int unsigned NrEntries = 4,
  localparam int unsigned IdxW = $clog2(NrEntries)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrEntries-1:0] valid_i,
  input  logic                 install_i,
  output logic [IdxW-1:0]      victim_o
);
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] free_idx;
  logic            all_valid;

  always_comb begin
    free_idx = '0;
    for (int i = int'(NrEntries) - 1; i >= 0; i--) begin
      if (!valid_i[i]) free_idx = IdxW'(i);
    end
  end

  assign all_valid = &valid_i;
  assign victim_o  = all_valid ? rr_q : free_idx;

  // NrEntries is a power of two, so the wrap is free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (install_i && all_valid) begin
      rr_q <= rr_q + IdxW'(1);
    end
  end
endmodule

// File: rtl/snitch_vm_tlb.sv
// Fully-associative TLB: 0-cycle hit, miss costs walk latency + 2 cycles.
// The core holds its request until lookup_ready_o; the PTW holds ours until ptw_ready_i.
module snitch_vm_tlb import snitch_pkg::*; #(
  parameter int unsigned NrEntries = 4,
  parameter int unsigned PPNSize   = $bits(pa_t)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               lookup_valid_i,
  output logic               lookup_ready_o,
  input  va_t                lookup_va_i,
  output logic [PPNSize-1:0] lookup_ppn_o,
  output logic [5:0]         lookup_flags_o,
  output logic               lookup_fault_o,
  output logic               ptw_valid_o,
  input  logic               ptw_ready_i,
  output va_t                ptw_va_o,
  input  l0_pte_t            ptw_pte_i,
  input  logic               ptw_is_4mega_i
);
  localparam int unsigned IdxW = $clog2(NrEntries);

  tlb_entry_t          entries_q [NrEntries];
  tlb_state_e          state_q;
  logic                flush_pending_q;
  logic [PPNSize-1:0]  resp_ppn_q;
  pte_flags_t          resp_flags_q;

  logic [NrEntries-1:0] hit_vec;
  logic [NrEntries-1:0] valid_vec;
  logic                 hit;
  logic [PPNSize-1:0]   hit_ppn;
  pte_flags_t           hit_flags;
  logic [PPNSize-1:0]   walk_ppn;
  logic                 install;
  logic [IdxW-1:0]      victim_idx;

  always_comb begin
    hit_vec   = '0;
    valid_vec = '0;
    hit_ppn   = '0;
    hit_flags = '0;
    for (int i = 0; i < int'(NrEntries); i++) begin
      valid_vec[i] = entries_q[i].valid;
      hit_vec[i]   = entries_q[i].valid && (entries_q[i].vpn1 == lookup_va_i.vpn1) &&
                     (entries_q[i].is_4mega || (entries_q[i].vpn0 == lookup_va_i.vpn0));
      if (hit_vec[i]) begin
        hit_ppn   = entries_q[i].is_4mega ? PPNSize'({entries_q[i].pte.pa.ppn1, lookup_va_i.vpn0})
                                          : PPNSize'(entries_q[i].pte.pa);
        hit_flags = entries_q[i].pte.flags;
      end
    end
  end

  assign hit      = |hit_vec;
  assign walk_ppn = ptw_is_4mega_i ? PPNSize'({ptw_pte_i.pa.ppn1, lookup_va_i.vpn0})
                                   : PPNSize'(ptw_pte_i.pa);
  // A flush seen at any point of the walk, including its last cycle, blocks the install.
  assign install  = (state_q == Refill) && ptw_ready_i && ptw_pte_i.flags.a &&
                    !flush_pending_q && !flush_i;

  snitch_vm_tlb_victim #(.NrEntries(NrEntries)) i_victim (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_vec),
    .install_i (install),
    .victim_o  (victim_idx)
  );

  assign ptw_valid_o = !rst_i && (state_q == Refill);
  assign ptw_va_o    = lookup_va_i;

  always_comb begin
    lookup_ready_o = 1'b0;
    lookup_ppn_o   = '0;
    lookup_flags_o = '0;
    lookup_fault_o = 1'b0;
    if (!rst_i) begin
      if (state_q == Respond) begin
        lookup_ready_o = 1'b1;
        lookup_ppn_o   = resp_ppn_q;
        lookup_flags_o = resp_flags_q;
        lookup_fault_o = !resp_flags_q.a;
      end else if (state_q == Idle && lookup_valid_i && hit && !flush_i) begin
        lookup_ready_o = 1'b1;
        lookup_ppn_o   = hit_ppn;
        lookup_flags_o = hit_flags;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= Idle;
      flush_pending_q <= 1'b0;
      resp_ppn_q      <= '0;
      resp_flags_q    <= '0;
      for (int i = 0; i < int'(NrEntries); i++) entries_q[i].valid <= 1'b0;
    end else begin
      case (state_q)
        Idle: if (lookup_valid_i && !hit && !flush_i) state_q <= Refill;
        Refill: begin
          if (flush_i) flush_pending_q <= 1'b1;
          if (ptw_ready_i) begin
            resp_ppn_q   <= walk_ppn;
            resp_flags_q <= ptw_pte_i.flags;
            state_q      <= Respond;
          end
        end
        Respond: begin
          flush_pending_q <= 1'b0;
          state_q         <= Idle;
        end
        default: state_q <= Idle;
      endcase
      if (install) begin
        entries_q[victim_idx] <= '{valid: 1'b1, vpn1: lookup_va_i.vpn1, vpn0: lookup_va_i.vpn0,
                                   is_4mega: ptw_is_4mega_i, pte: ptw_pte_i};
      end
      if (flush_i) begin
        for (int i = 0; i < int'(NrEntries); i++) entries_q[i].valid <= 1'b0;
      end
    end
  end

  logic req_pend_q;
  va_t  req_va_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pend_q <= 1'b0;
      req_va_q   <= '0;
    end else begin
      req_pend_q <= lookup_valid_i && !lookup_ready_o;
      req_va_q   <= lookup_va_i;
      if (lookup_valid_i) assert ($onehot0(hit_vec));
      if (req_pend_q) assert (lookup_valid_i && (lookup_va_i == req_va_q));
    end
  end
endmodule

// File: doc/snitch_vm_tlb.md
Name: snitch_vm_tlb

Overview:
Fully-associative translation lookaside buffer that acts as the requester on the page table walker's translation interface. It serves core-side VA lookups from a small entry array. On a miss it issues one walk request, then consumes the returned L0 PTE and superpage flag. It installs successful translations and reports faults back to the core-side port.

Parameters:
NrEntries, 4, number of fully-associative entries (power of two, >=2)
PPNSize, 22, physical page number width; equals $bits(pa_t)
pa_t, logic, physical page struct with fields ppn1 and ppn0 (ppn0 is VpnSize wide)
l0_pte_t, logic, compact PTE struct with fields pa (pa_t) and flags {d,a,u,x,w,r}

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  invalidate all entries (sfence.vma)
lookup_valid_i  in  1  core lookup request
lookup_ready_o  out  1  lookup completed this cycle (response valid)
lookup_va_i  in  va_t  virtual address {vpn1, vpn0, offset}
lookup_ppn_o  out  PPNSize  translated PPN
lookup_flags_o  out  6  {d,a,u,x,w,r} of the translation
lookup_fault_o  out  1  walk failed (PTE flags.a==0)
ptw_valid_o  out  1  walk request
ptw_ready_i  in  1  walk done, PTE valid
ptw_va_o  out  va_t  VA for walk
ptw_pte_i  in  l0_pte_t  returned PTE
ptw_is_4mega_i  in  1  returned PTE is a 4-mega superpage

Behaviour:
- Reset (rst_i high at a clock edge): all entry valid bits 0, replacement pointer 0, state Idle. lookup_ready_o, lookup_fault_o and ptw_valid_o are 0 during and after reset. lookup_ppn_o and lookup_flags_o are '0. Reset mid-walk drops ptw_valid_o immediately, and no install occurs.
- Entry contents: valid, vpn1, vpn0, is_4mega, pte (l0_pte_t).
- Hit: valid entry with vpn1 match and either is_4mega=1 or vpn0 match. Multiple hits must not occur; assert at most one hit.
- PPN output:
  - Normal entry: {pte.pa.ppn1, pte.pa.ppn0}.
  - Superpage: {pte.pa.ppn1, lookup_va_i.vpn0}.
- FSM states:
  - Idle:
    - lookup_valid_i & hit & !flush_i: lookup_ready_o=1 combinationally in the same cycle (0-cycle hit latency), fault=0, and state stays Idle.
    - lookup_valid_i & !hit & !flush_i: go to Refill.
    - flush_i: clear all valid bits; no acknowledge that cycle. Flush has priority over hit.
  - Refill:
    - ptw_valid_o=1 and ptw_va_o=lookup_va_i; both held stable until ptw_ready_i.
    - On ptw_ready_i:
      - If ptw_pte_i.flags.a=1 and no flush is pending, install into the victim slot and register the response.
      - In all cases go to Respond.
    - flush_i during Refill sets flush_pending. The handshake still completes, because a walk cannot be aborted, but nothing is installed. All valid bits are cleared on the flush cycle.
  - Respond:
    - lookup_ready_o=1 with the registered ppn/flags.
    - lookup_fault_o = !flags.a.
    - Clear flush_pending; next state Idle.
  - Miss latency: walk latency + 2 cycles (Refill exit, Respond).
- Victim selection: the lowest-index invalid entry. If all entries are valid, use the round-robin pointer, which increments (mod NrEntries) only on an install into a full array.
- Protocol: lookup_valid_i and lookup_va_i stay stable until lookup_ready_o; assert this. The lookup-side is not allowed to drop a request.
- Faulting translations are never cached. A repeated faulting VA re-walks each time.

Decomposition:
- snitch_pkg already provides PageShift, VpnSize and va_t. Add there:
  - the tlb_entry_t typedef {valid, vpn1, vpn0, is_4mega, l0_pte_t}
  - the tlb_state_e enum {Idle, Refill, Respond}
- One sub-module, snitch_vm_tlb_victim: a priority-encoder plus round-robin pointer that outputs the victim index. It holds the pointer register and the increment-on-full-install logic.

Test Plan:
- Cold miss: VA=0x0040_3123 (Sv32: vpn1=1, vpn0=3), PTW returns ppn {ppn1=0x5,ppn0=0x7}, a=1, is_4mega=0 after 5 cycles → ptw_valid_o held 5 cycles; lookup_ready_o 2 cycles later with ppn=0x1407, fault=0. Repeat same VA → ready in same cycle, no ptw_valid_o.
- Superpage: install vpn1=2 with is_4mega=1, ppn1=0x9 → later lookup vpn1=2, vpn0=0x3FF hits with ppn=0x27FF, no walk.
- Fault: PTW returns flags.a=0 → lookup_fault_o=1 for one cycle with ready. Repeat the same VA → a new walk is issued and the entry count is unchanged.
- Replacement: fill 4 entries (VPNs A–D), then miss E → E replaces A (pointer 0→1); F replaces B; lookup A misses.
- Flush during Refill: assert flush_i one cycle mid-walk → walk completes, response is delivered, and nothing is installed. All prior entries miss afterwards.
- Reset mid-walk: rst_i high during Refill → next cycle ptw_valid_o=0 and state Idle. Previously cached VA misses.
